// File: rtl/lram_fill_sched.sv
// lram_fill_sched: per-scanline scheduler for the ping-pong line RAM feeding video output.
// Each line start clears the back bank, then grants the write port to the enabled layers
// from lowest to highest priority so that later layers overwrite earlier ones.
// Ports:
//   gclk, rstn              clock, asynchronous active-low reset
//   hcomp                   1-cycle line-start pulse
//   lramsel                 bank currently displayed
//   fill_line/clr_len/layer_en  line parameters, sampled on hcomp
//   req_start/req_ready     per-layer start pulse and one-hot grant
//   req_line                latched line number
//   req_valid/addr/data/last  per-layer pixel stream
//   wr_en/wr_bank/wr_addr/wr_data  line RAM write port
//   busy/done/overrun/ovr_cnt  status
module lram_fill_sched #(
    parameter int NREQ = 4,
    parameter int AW = 10,
    parameter int DW = 16,
    parameter logic [DW-1:0] CLR_VAL = 16'h0000,
    parameter logic [DW-1:0] TRANSP = 16'h0000
) (
    input  logic                gclk,
    input  logic                rstn,
    input  logic                hcomp,
    input  logic                lramsel,
    input  logic [9:0]          fill_line,
    input  logic [AW:0]         clr_len,
    input  logic [NREQ-1:0]     layer_en,
    output logic [NREQ-1:0]     req_start,
    output logic [9:0]          req_line,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                wr_en,
    output logic                wr_bank,
    output logic [AW-1:0]       wr_addr,
    output logic [DW-1:0]       wr_data,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic [7:0]          ovr_cnt
);
    localparam int KW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, CLEAR, START, XFER, DONE} state_t;

    state_t          state_q, state_d;
    logic [9:0]      line_q, line_d;
    logic [AW:0]     len_q, len_d, ptr_q, ptr_d;
    logic [NREQ-1:0] en_q, en_d;
    logic [KW-1:0]   k_q, k_d, nxt_k;
    logic            bank_q, bank_d, nxt_ok, xfer, keep;
    logic [7:0]      ovr_q, ovr_d;
    logic [AW-1:0]   px_addr;
    logic [DW-1:0]   px_data;
    int              lo;

    assign px_addr  = req_addr[k_q*AW +: AW];
    assign px_data  = req_data[k_q*DW +: DW];
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign overrun  = hcomp && state_q != IDLE;
    // A new line start cancels any transfer offered in the same cycle.
    assign xfer     = state_q == XFER && req_valid[k_q] && !hcomp;
    // Transparent pixels only punch through above the backdrop; off-line addresses are dropped.
    assign keep     = !((k_q != '0 && px_data == TRANSP) || {1'b0, px_addr} >= len_q);
    assign req_line = line_q;
    assign ovr_cnt  = ovr_q;
    assign wr_bank  = bank_d;

    // Next enabled layer: lowest overall when leaving CLEAR, otherwise strictly above k.
    always_comb begin
        lo = (state_q == CLEAR) ? 0 : int'(k_q) + 1;
        nxt_ok = 1'b0;
        nxt_k = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (en_q[i] && i >= lo) begin
                nxt_ok = 1'b1;
                nxt_k = KW'(i);
            end
    end

    always_comb begin
        state_d = state_q;
        line_d = line_q;
        len_d = len_q;
        en_d = en_q;
        ptr_d = ptr_q;
        k_d = k_q;
        ovr_d = ovr_q;
        // The display bank has already swapped by the first clear cycle; capture its complement there.
        bank_d = (state_q == CLEAR && ptr_q == '0) ? ~lramsel : bank_q;
        req_start = '0;
        req_ready = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            CLEAR: begin
                wr_en = 1'b1;
                wr_addr = ptr_q[AW-1:0];
                wr_data = CLR_VAL;
                ptr_d = ptr_q + ONE;
                if (ptr_q == len_q - ONE) begin
                    state_d = nxt_ok ? START : DONE;
                    k_d = nxt_k;
                end
            end
            START: begin
                req_start[k_q] = 1'b1;
                state_d = XFER;
            end
            XFER: begin
                req_ready[k_q] = 1'b1;
                wr_en = xfer && keep;
                wr_addr = px_addr;
                wr_data = px_data;
                if (xfer && req_last[k_q]) begin
                    state_d = nxt_ok ? START : DONE;
                    k_d = nxt_k;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hcomp) begin
            state_d = CLEAR;
            line_d = fill_line;
            len_d = clr_len;
            en_d = layer_en;
            ptr_d = '0;
            if (state_q != IDLE)
                ovr_d = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;
        end
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            line_q <= '0;
            len_q <= '0;
            en_q <= '0;
            ptr_q <= '0;
            k_q <= '0;
            bank_q <= 1'b1;
            ovr_q <= '0;
        end else begin
            state_q <= state_d;
            line_q <= line_d;
            len_q <= len_d;
            en_q <= en_d;
            ptr_q <= ptr_d;
            k_q <= k_d;
            bank_q <= bank_d;
            ovr_q <= ovr_d;
        end
    end
endmodule
